// File: rtl/inst_fetch.sv
// Instruction fetch stage: streams a program into instruction RAM while in LOAD,
// then fetches one word per cycle into a stallable, redirectable IF/ID register.
module inst_fetch #(
  parameter int          W        = 32,
  parameter int          H        = 8,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_valid,
  input  logic [W-1:0] ld_data,
  input  logic         ld_last,
  output logic         ld_ready,
  output logic [W-1:0] ram_pc,
  output logic         ram_re,
  output logic         ram_we,
  output logic [W-1:0] ram_wdata,
  input  logic [W-1:0] ram_rdata,
  input  logic         redirect,
  input  logic [W-1:0] redirect_pc,
  input  logic         id_ready,
  output logic         id_valid,
  output logic [W-1:0] id_inst,
  output logic [W-1:0] id_pc,
  output logic         loading
);

  localparam int AW = H + 2;

  typedef enum logic {
    LOAD,
    FETCH
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  loadAddr_q, loadAddr_d;
  logic [W-1:0]   pc_q, pc_d;
  logic           idValid_q, idValid_d;
  logic [W-1:0]   idInst_q, idInst_d;
  logic [W-1:0]   idPc_q, idPc_d;
  logic           advance;

  assign advance = (state_q == FETCH) && (!idValid_q || id_ready);

  // Redirect outranks both advance and stall; the load address wraps in AW bits.
  always_comb begin
    state_d    = state_q;
    loadAddr_d = loadAddr_q;
    pc_d       = pc_q;
    idValid_d  = idValid_q;
    idInst_d   = idInst_q;
    idPc_d     = idPc_q;
    case (state_q)
      LOAD: begin
        if (ld_valid) begin
          loadAddr_d = loadAddr_q + AW'(4);
          if (ld_last) begin
            state_d   = FETCH;
            pc_d      = RESET_PC;
            idValid_d = 1'b0;
          end
        end
      end
      FETCH: begin
        if (redirect) begin
          pc_d      = redirect_pc & ~W'(3);
          idValid_d = 1'b0;
        end else if (advance) begin
          idInst_d  = ram_rdata;
          idPc_d    = pc_q;
          idValid_d = 1'b1;
          pc_d      = pc_q + W'(4);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      loadAddr_q <= '0;
      pc_q       <= RESET_PC;
      idValid_q  <= 1'b0;
      idInst_q   <= '0;
      idPc_q     <= '0;
    end else begin
      state_q    <= state_d;
      loadAddr_q <= loadAddr_d;
      pc_q       <= pc_d;
      idValid_q  <= idValid_d;
      idInst_q   <= idInst_d;
      idPc_q     <= idPc_d;
    end
  end

  // RAM strobes are gated by rst so nothing is written or read while resetting.
  assign loading   = rst || (state_q == LOAD);
  assign ld_ready  = !rst && (state_q == LOAD);
  assign ram_we    = ld_ready && ld_valid;
  assign ram_re    = !rst && (state_q == FETCH);
  assign ram_wdata = ld_data;
  assign ram_pc    = (state_q == LOAD) ? W'(loadAddr_q) : pc_q;

  assign id_valid  = idValid_q;
  assign id_inst   = idInst_q;
  assign id_pc     = idPc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ram_re && ram_we));
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, wrap sequence, then random traffic
// checked against a word-level model of the load/fetch behaviour.
module tb_inst_fetch;

  localparam int W = 32;
  localparam int H = 4;
  localparam int DEPTH = 1 << H;
  localparam logic [W-1:0] RESET_PC = '0;

  logic         clk = 1'b0;
  logic         rst, ld_valid, ld_last, ld_ready, ram_re, ram_we;
  logic         redirect, id_ready, id_valid, loading;
  logic [W-1:0] ld_data, ram_pc, ram_wdata, ram_rdata, redirect_pc, id_inst, id_pc;

  logic [W-1:0] ram [DEPTH];
  bit           ramWritten [DEPTH];

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state
  bit             mLoading;
  int unsigned    mLoadCount;
  logic [W-1:0]   mPc;
  bit             mIdValid;
  logic [W-1:0]   mIdInst, mIdPc;
  logic [W-1:0]   mMem [DEPTH];

  typedef struct {
    logic         rst, ldValid, ldLast, redirect, idReady;
    logic [31:0]  ldData, redirectPc;
    logic         eLoading, eLdReady, eRamWe, eRamRe;
    logic         chkPc;
    logic [31:0]  eRamPc;
    logic         eIdValid;
    logic         chkId;
    logic [31:0]  eIdPc, eIdInst;
  } vec_t;

  vec_t vecs [$];

  inst_fetch #(.W(W), .H(H), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ram_pc(ram_pc), .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .loading(loading)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] initWord(int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Behavioural instruction RAM with combinational read
  assign ram_rdata = ramWritten[ram_pc[H+1:2]] ? ram[ram_pc[H+1:2]] : initWord(int'(ram_pc[H+1:2]));

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_pc[H+1:2]]        <= ram_wdata;
      ramWritten[ram_pc[H+1:2]] <= 1'b1;
    end
  end

  function automatic int wordIdx(logic [W-1:0] byteAddr);
    return int'((byteAddr >> 2) % 32'(DEPTH));
  endfunction

  function automatic vec_t mk(bit r, bit lv, bit ll, logic [31:0] ld, bit rd, logic [31:0] rpc,
                              bit ir, bit eL, bit eRdy, bit eWe, bit eRe, bit cPc,
                              logic [31:0] ePc, bit eV, bit cId, logic [31:0] eIPc,
                              logic [31:0] eInst);
    vec_t v;
    v.rst = r; v.ldValid = lv; v.ldLast = ll; v.ldData = ld;
    v.redirect = rd; v.redirectPc = rpc; v.idReady = ir;
    v.eLoading = eL; v.eLdReady = eRdy; v.eRamWe = eWe; v.eRamRe = eRe;
    v.chkPc = cPc; v.eRamPc = ePc; v.eIdValid = eV; v.chkId = cId;
    v.eIdPc = eIPc; v.eIdInst = eInst;
    return v;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(bit r, bit lv, bit ll, logic [31:0] ld, bit rd,
                               logic [31:0] rpc, bit ir);
    @(negedge clk);
    rst = r; ld_valid = lv; ld_last = ll; ld_data = ld;
    redirect = rd; redirect_pc = rpc; id_ready = ir;
    #1;
  endtask

  // Compares DUT outputs with what the model predicts for the current inputs
  task automatic checkOutput();
    bit expRdy;
    expRdy = !rst && mLoading;
    checkVal("loading", 32'(loading), 32'(rst || mLoading));
    checkVal("ld_ready", 32'(ld_ready), 32'(expRdy));
    checkVal("ram_we", 32'(ram_we), 32'(expRdy && ld_valid));
    checkVal("ram_re", 32'(ram_re), 32'(!rst && !mLoading));
    if (!rst)
      checkVal("ram_pc", ram_pc, mLoading ? ((mLoadCount * 4) % (4 * DEPTH)) : mPc);
    if (expRdy && ld_valid)
      checkVal("ram_wdata", ram_wdata, ld_data);
    checkVal("id_valid", 32'(id_valid), 32'(mIdValid));
    if (mIdValid) begin
      checkVal("id_pc", id_pc, mIdPc);
      checkVal("id_inst", id_inst, mIdInst);
    end
  endtask

  task automatic checkVector(vec_t v, int row);
    string tag;
    tag = $sformatf("row%0d", row);
    checkVal({tag, ".loading"}, 32'(loading), 32'(v.eLoading));
    checkVal({tag, ".ld_ready"}, 32'(ld_ready), 32'(v.eLdReady));
    checkVal({tag, ".ram_we"}, 32'(ram_we), 32'(v.eRamWe));
    checkVal({tag, ".ram_re"}, 32'(ram_re), 32'(v.eRamRe));
    if (v.chkPc) checkVal({tag, ".ram_pc"}, ram_pc, v.eRamPc);
    checkVal({tag, ".id_valid"}, 32'(id_valid), 32'(v.eIdValid));
    if (v.chkId) begin
      checkVal({tag, ".id_pc"}, id_pc, v.eIdPc);
      checkVal({tag, ".id_inst"}, id_inst, v.eIdInst);
    end
  endtask

  // Word-level model: a program counter walking a memory image the loader filled
  task automatic modelUpdate();
    if (rst) begin
      mLoading = 1; mLoadCount = 0; mPc = RESET_PC;
      mIdValid = 0; mIdInst = '0; mIdPc = '0;
    end else if (mLoading) begin
      if (ld_valid) begin
        mMem[mLoadCount % DEPTH] = ld_data;
        mLoadCount++;
        if (ld_last) begin
          mLoading = 0; mPc = RESET_PC; mIdValid = 0;
        end
      end
    end else if (redirect) begin
      mPc = redirect_pc & ~32'h3;
      mIdValid = 0;
    end else if (!mIdValid || id_ready) begin
      mIdInst = mMem[wordIdx(mPc)];
      mIdPc = mPc;
      mIdValid = 1;
      mPc = mPc + 4;
    end
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelUpdate();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mMem[i] = initWord(i);
    mLoading = 1; mLoadCount = 0; mPc = RESET_PC;
    mIdValid = 0; mIdInst = '0; mIdPc = '0;
    rst = 1; ld_valid = 0; ld_last = 0; ld_data = '0;
    redirect = 0; redirect_pc = '0; id_ready = 0;
    repeat (2) @(posedge clk);

    //          r lv ll data      rd rpc      ir  L Rdy We Re cPc pc  V cId idpc inst
    vecs.push_back(mk(1,1,0,32'h99, 0,32'h0, 0,  1,0,0,0, 1,32'h0, 0,1,32'h0,32'h0));
    vecs.push_back(mk(0,1,0,32'h11, 0,32'h0, 0,  1,1,1,0, 1,32'h0, 0,1,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 0,  1,1,0,0, 1,32'h4, 0,1,32'h0,32'h0));
    vecs.push_back(mk(0,1,0,32'h22, 0,32'h0, 0,  1,1,1,0, 1,32'h4, 0,1,32'h0,32'h0));
    vecs.push_back(mk(0,1,1,32'h33, 1,32'h40,0,  1,1,1,0, 1,32'h8, 0,1,32'h0,32'h0));
    vecs.push_back(mk(0,1,0,32'h77, 0,32'h0, 1,  0,0,0,1, 1,32'h0, 0,1,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 1,  0,0,0,1, 1,32'h4, 1,1,32'h0,32'h11));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 1,  0,0,0,1, 1,32'h8, 1,1,32'h4,32'h22));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 0,  0,0,0,1, 1,32'hC, 1,1,32'h8,32'h33));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 0,  0,0,0,1, 1,32'hC, 1,1,32'h8,32'h33));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 1,  0,0,0,1, 1,32'hC, 1,1,32'h8,32'h33));
    vecs.push_back(mk(0,0,0,32'h0,  1,32'hA, 0,  0,0,0,1, 1,32'h10,1,1,32'hC,32'hA500_0003));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 0,  0,0,0,1, 1,32'h8, 0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 0,  0,0,0,1, 1,32'hC, 1,1,32'h8,32'h33));
    vecs.push_back(mk(1,0,0,32'h0,  0,32'h0, 1,  1,0,0,0, 0,32'h0, 1,1,32'h8,32'h33));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0, 0,  1,1,0,0, 1,32'h0, 0,1,32'h0,32'h0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].ldValid, vecs[i].ldLast, vecs[i].ldData,
                    vecs[i].redirect, vecs[i].redirectPc, vecs[i].idReady);
      checkVector(vecs[i], i);
      clockEdge();
    end

    // Load one word more than the RAM holds; the last write lands back at 0
    for (int k = 0; k <= DEPTH; k++) begin
      applyStimulus(0, 1, k == DEPTH, 32'h100 + 32'(k), 0, 32'h0, 0);
      checkOutput();
      if (k == DEPTH) begin
        checkVal("wrap.ram_pc", ram_pc, 32'h0);
        checkVal("wrap.ram_we", 32'(ram_we), 32'h1);
      end
      clockEdge();
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput();
    checkVal("wrap.loading", 32'(loading), 32'h0);
    clockEdge();
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput();
    checkVal("wrap.id_inst", id_inst, 32'h100 + 32'(DEPTH));
    checkVal("wrap.id_pc", id_pc, 32'h0);
    clockEdge();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 255), $urandom_range(0, 2) != 0);
      checkOutput();
      clockEdge();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
